// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
package alu_seq_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/addn.sv
// WIDTH-bit ripple-carry adder shared by ADD, SUB and the multiplier accumulator.
module addn #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  logic [WIDTH:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus an optional shift-add
// multiplier compiled in with ALU_SEQ_MUL_EN (otherwise opcode 7 returns zero).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH              = 8,
  parameter int MUL_CYCLES_PER_BIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    left,
  input  logic [WIDTH-1:0]    right,
  input  logic                use_carry,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                status_out,
  output logic                zero_out,
  output logic                neg_out
);

  if (WIDTH < 4 || WIDTH > 32 || MUL_CYCLES_PER_BIT < 1 || MUL_CYCLES_PER_BIT > 4)
  begin : g_param_chk
    $error("alu_seq: WIDTH or MUL_CYCLES_PER_BIT out of range");
  end

  opcode_e          op;
  logic             accept;
  logic             busy;
  logic             carry_q;
  logic             cin;
  logic             is_sub;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_ci;
  logic             add_co;

  logic [WIDTH-1:0] alu_res;
  logic             alu_st;

  logic             res_load;
  logic [WIDTH-1:0] res_val;
  logic             res_st;

  assign op       = opcode_e'(opcode);
  assign in_ready = !busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign cin      = use_carry & carry_q;
  assign is_sub   = (op == OP_SUB);

  addn #(.WIDTH(WIDTH)) u_addn (
    .a     (add_a),
    .b     (add_b),
    .c_in  (add_ci),
    .s     (add_s),
    .c_out (add_co)
  );

  // SUB runs as A + ~B + !cin, so the adder carry-out is the inverted borrow.
  always_comb begin
    alu_res = '0;
    alu_st  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_s;
        alu_st  = add_co;
      end
      OP_SUB: begin
        alu_res = add_s;
        alu_st  = ~add_co;
      end
      OP_AND: alu_res = left & right;
      OP_OR:  alu_res = left | right;
      OP_XOR: alu_res = left ^ right;
      OP_SHL: begin
        alu_res = {left[WIDTH-2:0], cin};
        alu_st  = left[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {cin, left[WIDTH-1:1]};
        alu_st  = left[0];
      end
      default: begin
        alu_res = '0;
        alu_st  = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int                    BIT_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WIDTH - 1);
  localparam logic [1:0]            LAST_CYC  = 2'(MUL_CYCLES_PER_BIT - 1);

  mul_state_e           state;
  mul_state_e           state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     acc_hi;
  logic [WIDTH-1:0]     acc_lo;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [1:0]           cyc_cnt;
  logic                 mul_start;
  logic                 bit_step;
  logic                 mul_last;
  logic [WIDTH-1:0]     mul_res;
  logic                 mul_st;

  assign busy      = (state == ST_MUL);
  assign mul_start = accept && (op == OP_MUL);
  assign bit_step  = busy && (cyc_cnt == LAST_CYC);
  assign mul_last  = bit_step && (bit_cnt == LAST_BIT);

  // While busy the adder accumulates the multiplicand into the high half.
  assign add_a  = busy ? acc_hi : left;
  assign add_b  = busy ? (acc_lo[0] ? mcand : '0) : (is_sub ? ~right : right);
  assign add_ci = busy ? 1'b0 : (is_sub ? ~cin : cin);

  // Product after the final shift: {add_co, add_s, acc_lo} >> 1.
  assign mul_res = {add_s[0], acc_lo[WIDTH-1:1]};
  assign mul_st  = |{add_co, add_s[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // DONE lasts one cycle and accepts new work exactly like IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: state_nxt = mul_start ? ST_MUL : ST_IDLE;
      ST_MUL:           if (mul_last) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (mul_start) begin
      mcand   <= left;
      acc_hi  <= '0;
      acc_lo  <= right;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (busy) begin
      if (bit_step) begin
        cyc_cnt          <= '0;
        bit_cnt          <= bit_cnt + 1'b1;
        {acc_hi, acc_lo} <= {add_co, add_s, acc_lo[WIDTH-1:1]};
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
    end
  end

  assign res_load = (accept && (op != OP_MUL)) || mul_last;
  assign res_val  = mul_last ? mul_res : alu_res;
  assign res_st   = mul_last ? mul_st  : alu_st;
`else
  assign busy     = 1'b0;
  assign add_a    = left;
  assign add_b    = is_sub ? ~right : right;
  assign add_ci   = is_sub ? ~cin : cin;
  assign res_load = accept;
  assign res_val  = alu_res;
  assign res_st   = alu_st;
`endif

  // Output slot: loads on any result, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      status_out <= 1'b0;
      zero_out   <= 1'b1;
      neg_out    <= 1'b0;
      carry_q    <= 1'b0;
      out_valid  <= 1'b0;
    end else if (res_load) begin
      result     <= res_val;
      status_out <= res_st;
      zero_out   <= (res_val == '0);
      neg_out    <= res_val[WIDTH-1];
      carry_q    <= res_st;
      out_valid  <= 1'b1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int    W    = 8;
  localparam int    CPB  = 1;
  localparam longint MASK = (longint'(1) << W) - 1;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = '0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic         use_carry = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         status_out;
  logic         zero_out;
  logic         neg_out;

  int     total = 0;
  int     bad = 0;
  bit     m_carry = 1'b0;
  longint exp_r = 0;
  bit     exp_st = 1'b0;
  int     exp_lat = 1;
  int     exp_op = 0;

  alu_seq #(.WIDTH(W), .MUL_CYCLES_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .left       (left),
    .right      (right),
    .use_carry  (use_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .status_out (status_out),
    .zero_out   (zero_out),
    .neg_out    (neg_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int op, input longint a, input longint b,
                                input longint ci, output longint r, output bit st);
    longint t;
    r  = 0;
    st = 1'b0;
    case (op)
      0: begin t = a + b + ci; r = t & MASK; st = (t > MASK); end
      1: begin t = a - b - ci; r = t & MASK; st = (t < 0); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = ((a << 1) | ci) & MASK; st = a[W-1]; end
      6: begin r = (a >> 1) | (ci << (W - 1)); st = a[0]; end
      default: if (MUL_ON) begin t = a * b; r = t & MASK; st = ((t >> W) != 0); end
    endcase
  endfunction

  task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic uc);
    int n = 0;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("issue_timeout", 0, 1);
    model(op, longint'(a), longint'(b), longint'(uc & m_carry), exp_r, exp_st);
    exp_op    = op;
    exp_lat   = (MUL_ON && op == 7) ? W * CPB + 1 : 1;
    in_valid  = 1'b1;
    opcode    = 3'(op);
    left      = a;
    right     = b;
    use_carry = uc;
    @(posedge clk); #1;
    // Scramble operands once the request is taken.
    in_valid  = 1'b0;
    opcode    = 3'($urandom);
    left      = W'($urandom);
    right     = W'($urandom);
    use_carry = 1'($urandom);
  endtask

  task automatic collect(input string tag);
    int n = 1;
    int lo = 0;
    while (!out_valid && n < 400) begin
      if (!in_ready) lo++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_res"}, longint'(result), exp_r);
    chk({tag, "_st"},  longint'(status_out), longint'(exp_st));
    chk({tag, "_z"},   longint'(zero_out), longint'(exp_r == 0));
    chk({tag, "_neg"}, longint'(neg_out), longint'(exp_r[W-1]));
    if (MUL_ON && exp_op == 7) chk({tag, "_busy"}, lo, W * CPB);
    m_carry = exp_st;
  endtask

  initial begin
    logic [W-1:0] hold;
    int stale;

    #12;
    chk("rst_vld",  longint'(out_valid), 0);
    chk("rst_zero", longint'(zero_out), 1);
    chk("rst_res",  longint'(result), 0);
    chk("rst_st",   longint'(status_out), 0);
    chk("rst_neg",  longint'(neg_out), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", longint'(in_ready), 1);

    issue(OP_ADD, 8'hF0, 8'h20, 1'b0); collect("add_ovf");
    issue(OP_ADD, 8'h01, 8'h01, 1'b1); collect("add_cin");
    issue(OP_SUB, 8'h05, 8'h07, 1'b0); collect("sub_brw");
    issue(OP_AND, 8'h0F, 8'hF0, 1'b0); collect("and_z");
    issue(OP_MUL, 8'h10, 8'h11, 1'b0); collect("mul_hi");
    issue(OP_MUL, 8'h03, 8'h05, 1'b0); collect("mul_lo");
    issue(OP_ADD, 8'hFF, 8'h01, 1'b0); collect("add_wrap");
    issue(OP_SHL, 8'h80, 8'h00, 1'b1); collect("shl_cin");
    issue(OP_SHR, 8'h01, 8'h00, 1'b1); collect("shr_cin");
    issue(OP_SUB, 8'h00, 8'h00, 1'b1); collect("sub_cin");
    issue(OP_OR,  8'hA0, 8'h05, 1'b0); collect("or");
    issue(OP_XOR, 8'hFF, 8'h0F, 1'b0); collect("xor");

    // Backpressure: result must hold and no new request may be taken.
    out_ready = 1'b0;
    hold = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_res", longint'(result), longint'(hold));
      chk("bp_vld", longint'(out_valid), 1);
      chk("bp_rdy", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", longint'(in_ready), 1);
    issue(OP_ADD, 8'h33, 8'h44, 1'b0); collect("bp_next");

    for (int i = 0; i < 60; i++) begin
      issue($urandom_range(0, 7), W'($urandom), W'($urandom), 1'($urandom));
      collect("rnd");
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset in the middle of a multiply.
    issue(OP_ADD, 8'hFF, 8'hFF, 1'b0); collect("pre_rst");
    issue(OP_MUL, 8'h07, 8'h09, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld",  longint'(out_valid), 0);
    chk("mrst_zero", longint'(zero_out), 1);
    chk("mrst_st",   longint'(status_out), 0);
    @(negedge clk) rst_n = 1'b1;
    m_carry = 1'b0;
    stale = 0;
    repeat (12) begin @(posedge clk); #1; if (out_valid) stale++; end
    chk("mrst_stale", stale, 0);
    issue(OP_ADD, 8'h01, 8'h01, 1'b1); collect("mrst_carry");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal 4..32).
REQ-002 SHALL have parameter MUL_CYCLES_PER_BIT, default 1, meaning cycles spent per multiplier bit (1..4).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port list, in order:
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  in_valid  in  1  operation request
  in_ready  out  1  block can accept request
  opcode  in  3  operation select
  left  in  WIDTH  operand A
  right  in  WIDTH  operand B
  use_carry  in  1  1: carry-in from internal carry flag; 0: carry-in = 0
  out_valid  out  1  result valid
  out_ready  in  1  consumer accepts result
  result  out  WIDTH  registered result
  status_out  out  1  carry/borrow/overflow flag of this result
  zero_out  out  1  result == 0
  neg_out  out  1  result MSB

Function
REQ-005 Request accepted on clk edge where in_valid && in_ready; result accepted where out_valid && out_ready.
REQ-006 in_ready SHALL = !busy && (!out_valid || out_ready); back-to-back single-cycle ops at full rate.
REQ-007 Opcodes: 0 ADD {c,r}=A+B+cin; 1 SUB {b,r}=A-B-cin, b=1 on borrow; 2 AND, 3 OR, 4 XOR, status=0; 5 SHL r={A[W-2:0],cin}, status=A[W-1]; 6 SHR r={cin,A[W-1:1]}, status=A[0]; 7 MUL (see REQ-012).
REQ-008 Single-cycle ops: result, flags and out_valid registered on the accept edge (latency 1).
REQ-009 Internal carry flag SHALL load status_out value on every result-producing edge; an op accepted on the next edge uses the new value.
REQ-010 Arithmetic modulo 2^WIDTH; carry/borrow is bit WIDTH of the unextended sum/difference.
REQ-011 Output registers SHALL hold while out_valid && !out_ready.
REQ-012 MUL: FSM IDLE->MUL->DONE; shift-add over WIDTH bits at MUL_CYCLES_PER_BIT cycles each; busy=1 in MUL; result=low WIDTH bits of product; status_out=1 iff high half nonzero; out_valid asserted on DONE entry; DONE->IDLE same edge.
REQ-013 Opcode 7 with MUL disabled (REQ-017): result=0, status_out=0, zero_out=1, latency 1.
REQ-014 Inputs sampled only on the accept edge; changes while busy ignored.

Reset
REQ-015 rst_n low SHALL asynchronously clear result, status_out, neg_out, out_valid, carry flag and FSM (IDLE); zero_out=1; in_ready=1 one cycle after release.
REQ-016 Reset mid-MUL SHALL abort the operation with no result.

Configuration
REQ-017 Macro ALU_SEQ_MUL_EN defined: MUL FSM and multiplier datapath compiled in; undefined: no FSM, busy tied 0, REQ-013 applies.

Structure
REQ-018 Package alu_seq_pkg SHALL hold opcode enum (OP_ADD..OP_MUL) and the 3-bit opcode width constant.
REQ-019 Sub-module addn (parametrised WIDTH ripple adder, a/b/c_in -> s/c_out) SHALL serve ADD, SUB (via B inversion) and MUL accumulation.

Verification
REQ-020 WIDTH=8: ADD 0xF0+0x20, use_carry=0 -> result 0x10, status 1, zero 0, next cycle.
REQ-021 Then ADD 0x01+0x01, use_carry=1 -> 0x03, status 0 (carry chain).
REQ-022 SUB 0x05-0x07, use_carry=0 -> 0xFE, status 1, neg 1; AND 0x0F&0xF0 -> 0x00, zero 1.
REQ-023 MUL 0x10*0x11 (macro on) -> in_ready low 8 cycles, result 0x10, status 1; MUL 0x03*0x05 -> 0x0F, status 0.
REQ-024 out_ready held 0 for 5 cycles with pending result -> result stable, in_ready 0; release -> next op accepted same edge.
REQ-025 rst_n low mid-MUL -> out_valid 0, carry 0, zero_out 1 immediately; no stale result after release.
